// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, Status/Cause field positions.
package cp0_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LO  = 8;
  localparam int ST_BEV    = 22;
  localparam int CA_EXC_LO = 2;
  localparam int CA_IP_LO  = 8;
  localparam int CA_TI     = 30;
  localparam int CA_BD     = 31;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_INT,
    EV_EXC,
    EV_ERET,
    EV_MTC0
  } cp0_event_e;

  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: prescaled Count, Compare match raises a sticky TI.
module cp0_timer
  import cp0_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [PW-1:0] pre;
  logic          wrap;
  logic [31:0]   count_inc;

  assign wrap      = (pre == PW'(COUNT_DIV - 1));
  assign count_inc = count + 32'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre     <= '0;
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      if (count_we) begin
        count <= wdata;
        pre   <= '0;
      end else if (wrap) begin
        count <= count_inc;
        pre   <= '0;
      end else begin
        pre <= pre + PW'(1);
      end
      // A Compare write clears TI even if the match lands on the same edge
      if (compare_we) begin
        compare <= wdata;
        ti      <= 1'b0;
      end else if (!count_we && wrap && (count_inc == compare)) begin
        ti <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_regfile.sv
// MIPS-32 CP0 register file with commit-point exception/interrupt arbitration.
// Optional timer (Count/Compare, Cause.TI) is built when CP0_TIMER_EN is defined.
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter int          NUM_HW_INT = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_HW_INT-1:0] ext_int,
  input  logic                  cmt_valid,
  input  logic [31:0]           cmt_pc,
  input  logic                  cmt_bd,
  input  logic                  cmt_exc,
  input  logic [4:0]            cmt_exccode,
  input  logic [31:0]           cmt_badva,
  input  logic                  cmt_eret,
  input  logic                  mtc0_we,
  input  logic [4:0]            cp0_addr,
  input  logic [2:0]            cp0_sel,
  input  logic [31:0]           cp0_wdata,
  output logic [31:0]           cp0_rdata,
  output logic                  flush,
  output logic [31:0]           flush_pc,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o
);

  logic        exl, ie, bd;
  logic [7:0]  im;
  logic [4:0]  exccode;
  logic [1:0]  ip_sw;
  logic [5:0]  ip_hw;
  logic [31:0] epc, badva;
  logic [7:0]  ip;
  logic        ti, int_req, mtc0_hit;
  logic [31:0] count, compare;
  cp0_event_e  ev_p0;

  assign mtc0_hit = (ev_p0 == EV_MTC0) && (cp0_sel == 3'd0);

`ifdef CP0_TIMER_EN
  logic wr_count, wr_compare;
  assign wr_count   = mtc0_hit && (cp0_addr == CP0_COUNT);
  assign wr_compare = mtc0_hit && (cp0_addr == CP0_COMPARE);

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (wr_count),
    .compare_we (wr_compare),
    .wdata      (cp0_wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );
`else
  assign count   = 32'd0;
  assign compare = 32'd0;
  assign ti      = 1'b0;
`endif

  assign ip       = {ip_hw[5] | ti, ip_hw[4:0], ip_sw};
  assign int_req  = ie & ~exl & (|(ip & im));
  assign status_o = {9'd0, 1'b1, 6'd0, im, 6'd0, exl, ie};
  assign cause_o  = {bd, ti, 14'd0, ip, 1'b0, exccode, 2'b00};
  assign epc_o    = epc;

  always_comb begin
    ev_p0 = EV_NONE;
    if (cmt_valid && int_req) ev_p0 = EV_INT;
    else if (cmt_exc)         ev_p0 = EV_EXC;
    else if (cmt_eret)        ev_p0 = EV_ERET;
    else if (mtc0_we)         ev_p0 = EV_MTC0;
  end

  // Stage p0 -> p1: architectural state and the one-cycle flush pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      exl      <= 1'b0;
      ie       <= 1'b0;
      im       <= '0;
      bd       <= 1'b0;
      exccode  <= '0;
      ip_sw    <= '0;
      ip_hw    <= '0;
      epc      <= '0;
      badva    <= '0;
      flush    <= 1'b0;
      flush_pc <= '0;
    end else begin
      ip_hw <= 6'(ext_int);
      flush <= 1'b0;
      case (ev_p0)
        EV_INT, EV_EXC: begin
          exccode <= (ev_p0 == EV_INT) ? EXC_INT : cmt_exccode;
          // A nested exception keeps the EPC/BD of the original fault
          if (!exl) begin
            epc <= cmt_bd ? (cmt_pc - 32'd4) : cmt_pc;
            bd  <= cmt_bd;
          end
          exl <= 1'b1;
          if ((ev_p0 == EV_EXC) && is_addr_exc(cmt_exccode)) badva <= cmt_badva;
          flush    <= 1'b1;
          flush_pc <= EXC_VECTOR;
        end
        EV_ERET: begin
          exl      <= 1'b0;
          flush    <= 1'b1;
          flush_pc <= epc;
        end
        EV_MTC0: begin
          if (mtc0_hit && (cp0_addr == CP0_STATUS)) begin
            im  <= cp0_wdata[ST_IM_LO +: 8];
            exl <= cp0_wdata[ST_EXL];
            ie  <= cp0_wdata[ST_IE];
          end
          if (mtc0_hit && (cp0_addr == CP0_CAUSE)) ip_sw <= cp0_wdata[CA_IP_LO +: 2];
          if (mtc0_hit && (cp0_addr == CP0_EPC))   epc   <= cp0_wdata;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cp0_rdata = 32'd0;
    if (cp0_sel == 3'd0) begin
      case (cp0_addr)
        CP0_BADVADDR: cp0_rdata = badva;
        CP0_COUNT:    cp0_rdata = count;
        CP0_COMPARE:  cp0_rdata = compare;
        CP0_STATUS:   cp0_rdata = status_o;
        CP0_CAUSE:    cp0_rdata = cause_o;
        CP0_EPC:      cp0_rdata = epc;
        default:      cp0_rdata = 32'd0;
      endcase
    end
  end

endmodule
